gb_lcd_tx: RTL and testbench

// Game Boy LCD interface transmitter: reads a 160x144, 2-bit-per-pixel framebuffer, or generates a test pattern.

---
 rtl/gb_lcd_tx.sv | 166 ++++++++++++++++
 tb/tb_gb_lcd_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_tx.sv
// DMG-style LCD transmitter: streams a 2bpp framebuffer (or an internal test pattern)
// as odata/oclk/ohsync/ovsync, with a one-pixel prefetch from a sync-read memory.
module gb_lcd_tx #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 144,
    parameter int V_BLANK = 10,
    parameter int H_BLANK = 48,
    parameter int HS_LEN  = 8,
    parameter int HALF    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pattern_sel,
    output logic        rd_en,
    output logic [14:0] rd_addr,
    input  logic [1:0]  rd_data,
    output logic [1:0]  odata,
    output logic        oclk,
    output logic        ohsync,
    output logic        ovsync,
    output logic        frame_done
);
    // state   | meaning
    // IDLE    | stopped, outputs low, waiting for enable
    // VSETUP  | one pixel period with ovsync high, pixel 0 of line 0 fetched
    // ACTIVE  | H_PIX clocked pixel periods of the current line
    // HBLANK  | H_BLANK periods, ohsync in the first HS_LEN, next line's pixel 0 fetched
    // VBLANK  | V_BLANK full-length lines, ohsync only, frame_done on the last clk
    typedef enum logic [2:0] {S_IDLE, S_VSETUP, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    localparam logic [7:0] PH_HI    = 8'(HALF);
    localparam logic [7:0] PH_LAST  = 8'(2*HALF-1);
    localparam logic [8:0] PX_ALAST = 9'(H_PIX-1);
    localparam logic [8:0] PX_LAST  = 9'(H_PIX+H_BLANK-1);
    localparam logic [8:0] HS_LO    = 9'(H_PIX);
    localparam logic [8:0] HS_HI    = 9'(H_PIX+HS_LEN);
    localparam logic [8:0] LN_ALAST = 9'(V_LINES-1);
    localparam logic [8:0] LN_LAST  = 9'(V_LINES+V_BLANK-1);

    state_t      state_q, state_d;
    logic [7:0]  ph_q, ph_d;
    logic [8:0]  px_q, px_d;
    logic [8:0]  ln_q, ln_d;
    logic        pat_q, pat_d;
    logic [14:0] fa_q;
    logic        pend_q;
    logic [1:0]  pf_q;
    logic        ph_end;
    logic        fetch;
    logic        frame_start;
    logic [1:0]  pat_pix;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        px_d    = px_q;
        ln_d    = ln_q;
        pat_d   = pat_q;
        ph_end  = (ph_q == PH_LAST);
        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSETUP;
                ph_d    = '0;
                px_d    = '0;
                ln_d    = '0;
                pat_d   = pattern_sel;
            end
        end else begin
            ph_d = ph_end ? 8'd0 : ph_q + 8'd1;
            if (ph_end) begin
                case (state_q)
                    S_VSETUP: begin
                        state_d = S_ACTIVE;
                        px_d    = '0;
                        ln_d    = '0;
                    end
                    S_ACTIVE: begin
                        px_d = px_q + 9'd1;
                        if (px_q == PX_ALAST) state_d = S_HBLANK;
                    end
                    S_HBLANK: begin
                        if (px_q == PX_LAST) begin
                            px_d    = '0;
                            ln_d    = ln_q + 9'd1;
                            state_d = (ln_q == LN_ALAST) ? S_VBLANK : S_ACTIVE;
                        end else begin
                            px_d = px_q + 9'd1;
                        end
                    end
                    S_VBLANK: begin
                        if (px_q == PX_LAST) begin
                            px_d = '0;
                            if (ln_q == LN_LAST) begin
                                ln_d    = '0;
                                state_d = enable ? S_VSETUP : S_IDLE;
                                pat_d   = pattern_sel;
                            end else begin
                                ln_d = ln_q + 9'd1;
                            end
                        end else begin
                            px_d = px_q + 9'd1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Reads go out on the first clk of a high phase; pixel 0 rides on the period before the line.
        fetch = !pat_d && (ph_d == PH_HI) &&
                ((state_d == S_VSETUP) ||
                 (state_d == S_ACTIVE && px_d != PX_ALAST) ||
                 (state_d == S_HBLANK && px_d == PX_LAST && ln_d != LN_ALAST));
        frame_start = (state_d == S_VSETUP) && (ph_d == 8'd0);
        pat_pix     = px_d[5:4] + ln_d[5:4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            px_q       <= '0;
            ln_q       <= '0;
            pat_q      <= 1'b0;
            fa_q       <= '0;
            pend_q     <= 1'b0;
            pf_q       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            odata      <= '0;
            oclk       <= 1'b0;
            ohsync     <= 1'b0;
            ovsync     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            px_q    <= px_d;
            ln_q    <= ln_d;
            pat_q   <= pat_d;
            rd_en   <= fetch;
            pend_q  <= rd_en;

            if (frame_start) fa_q <= '0;
            else if (fetch)  fa_q <= fa_q + 15'd1;

            if (fetch)                  rd_addr <= fa_q;
            else if (state_d == S_IDLE) rd_addr <= '0;

            if (pend_q) pf_q <= rd_data;

            // With HALF=2 the read lands on the same edge odata loads, so bypass the prefetch register.
            if (state_d != S_ACTIVE)  odata <= '0;
            else if (ph_d == 8'd0)    odata <= pat_d ? pat_pix : (pend_q ? rd_data : pf_q);

            oclk       <= (state_d == S_ACTIVE) && (ph_d >= PH_HI);
            ohsync     <= ((state_d == S_HBLANK) || (state_d == S_VBLANK)) &&
                          (px_d >= HS_LO) && (px_d < HS_HI);
            ovsync     <= (state_d == S_VSETUP) ||
                          (((state_d == S_ACTIVE) || (state_d == S_HBLANK)) && (ln_d == 9'd0));
            frame_done <= (state_d == S_VBLANK) && (ph_d == PH_LAST) &&
                          (px_d == PX_LAST) && (ln_d == LN_LAST);
        end
    end
endmodule

// File: tb/tb_gb_lcd_tx.sv
// Bench for gb_lcd_tx on a reduced 64x40 geometry: ramp framebuffer, receiver model,
// sync timing monitor, probe table and hand-written enable/reset sequences.
module tb_gb_lcd_tx;
    localparam int H_PIX   = 64;
    localparam int V_LINES = 40;
    localparam int V_BLANK = 2;
    localparam int H_BLANK = 10;
    localparam int HS_LEN  = 4;
    localparam int HALF    = 2;
    localparam int NPIX       = 2560;   // 64*40
    localparam int LINE_CLKS  = 296;    // (64+10)*4
    localparam int FRAME_CLKS = 12436;  // 4 + 42*296
    localparam int HS_WIDTH   = 16;     // 4*4
    localparam int HS_PER_FR  = 42;     // 40+2

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pattern_sel;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [1:0]  rd_data = 2'd0;
    logic [1:0]  odata;
    logic        oclk;
    logic        ohsync;
    logic        ovsync;
    logic        frame_done;

    gb_lcd_tx #(
        .H_PIX(H_PIX), .V_LINES(V_LINES), .V_BLANK(V_BLANK),
        .H_BLANK(H_BLANK), .HS_LEN(HS_LEN), .HALF(HALF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .odata(odata), .oclk(oclk), .ohsync(ohsync), .ovsync(ovsync),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ramp framebuffer: data = addr[1:0], one clk read latency.
    always @(posedge clk) if (rd_en) rd_data <= rd_addr[1:0];

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0, fr_rise_cnt = 0, fd_cnt = 0, rise_cyc = 0, last_frame_len = 0;
    int oclk_cnt = 0, last_oclk_cnt = 0, rd_cnt = 0, hs_cnt = 0, last_hs_cnt = 0;
    int hs_rise_cyc = 0, hs_wid_bad = 0, hs_per_bad = 0, addr_bad = 0, exp_addr = 0;
    int pix = 0, rise_to_clk = 0;
    bit first_pend = 0;
    logic p_ov = 0, p_oclk = 0, p_hs = 0;
    logic [1:0] cap [0:NPIX-1];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            p_ov = 0; p_oclk = 0; p_hs = 0; exp_addr = 0;
        end else begin
            if (ovsync && !p_ov) begin
                fr_rise_cnt++;
                last_frame_len = cyc - rise_cyc;
                rise_cyc = cyc;
                last_oclk_cnt = oclk_cnt; oclk_cnt = 0;
                rd_cnt = 0;
                last_hs_cnt = hs_cnt; hs_cnt = 0;
                pix = 0; exp_addr = 0; first_pend = 1;
            end
            if (oclk && !p_oclk) begin
                if (first_pend) begin
                    rise_to_clk = cyc - rise_cyc;
                    first_pend = 0;
                end
                if (pix < NPIX) cap[pix] = odata;
                pix++;
                oclk_cnt++;
            end
            if (ohsync && !p_hs) begin
                hs_cnt++;
                if (hs_cnt > 1 && (cyc - hs_rise_cyc) != LINE_CLKS) hs_per_bad++;
                hs_rise_cyc = cyc;
            end
            if (!ohsync && p_hs && (cyc - hs_rise_cyc) != HS_WIDTH) hs_wid_bad++;
            if (rd_en) begin
                if (int'(rd_addr) != exp_addr) addr_bad++;
                exp_addr++;
                rd_cnt++;
            end
            if (frame_done) fd_cnt++;
            p_ov = ovsync; p_oclk = oclk; p_hs = ohsync;
        end
    end

    typedef struct {
        bit         pat;
        int         x;
        int         y;
        logic [1:0] exp;
    } probe_t;
    probe_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({rd_en, rd_addr, odata, oclk, ohsync, ovsync, frame_done});
    endfunction

    // Reference image: ramp k mod 4, or the quadrant-sum test pattern.
    function automatic int count_bad(input bit pat);
        int bad = 0;
        for (int k = 0; k < NPIX; k++) begin
            int x = k % H_PIX;
            int y = k / H_PIX;
            int e = pat ? (((x >> 4) + (y >> 4)) & 3) : (k & 3);
            if (int'(cap[k]) != e) bad++;
        end
        return bad;
    endfunction

    task automatic run_probes(input bit pat);
        for (int i = 0; i < 12; i++)
            if (tbl[i].pat == pat)
                check($sformatf("probe%0d_x%0d_y%0d", i, tbl[i].x, tbl[i].y),
                      32'(cap[tbl[i].y*H_PIX + tbl[i].x]), 32'(tbl[i].exp));
    endtask

    task automatic wait_fd(input int target);
        for (int i = 0; i < FRAME_CLKS + 100 && fd_cnt < target; i++) tick();
        check($sformatf("frame_done_%0d_seen", target), 32'(fd_cnt >= target), 32'd1);
    endtask

    initial begin
        int nz;
        tbl[0]  = '{0, 0,  0,  2'd0};
        tbl[1]  = '{0, 1,  0,  2'd1};
        tbl[2]  = '{0, 63, 0,  2'd3};
        tbl[3]  = '{0, 0,  1,  2'd0};
        tbl[4]  = '{0, 5,  7,  2'd1};   // 453
        tbl[5]  = '{0, 63, 39, 2'd3};   // 2559
        tbl[6]  = '{1, 0,  0,  2'd0};
        tbl[7]  = '{1, 16, 0,  2'd1};
        tbl[8]  = '{1, 48, 32, 2'd1};
        tbl[9]  = '{1, 32, 16, 2'd3};
        tbl[10] = '{1, 20, 20, 2'd2};
        tbl[11] = '{1, 63, 39, 2'd1};

        rst_n = 0; enable = 0; pattern_sel = 0;
        repeat (3) tick();
        check("reset_outputs", outs(), 32'd0);
        rst_n = 1;
        repeat (5) tick();
        check("idle_without_enable", outs(), 32'd0);

        // Frame A: framebuffer; pattern_sel flips mid-frame and must wait for the next frame.
        enable = 1;
        repeat (3000) tick();
        pattern_sel = 1;
        wait_fd(1);
        check("A_read_count", rd_cnt, NPIX);
        check("A_addr_order_errors", addr_bad, 0);
        check("A_pixels_captured", pix, NPIX);
        check("A_image_errors", count_bad(0), 0);
        run_probes(0);
        for (int i = 0; i < 20 && fr_rise_cnt < 2; i++) tick();
        check("B_started", fr_rise_cnt, 2);
        check("A_frame_clks", last_frame_len, FRAME_CLKS);
        check("A_oclk_rises", last_oclk_cnt, NPIX);
        check("A_hsync_pulses", last_hs_cnt, HS_PER_FR);
        check("hsync_width_errors", hs_wid_bad, 0);
        check("hsync_period_errors", hs_per_bad, 0);
        check("vsync_to_first_oclk", rise_to_clk, 3*HALF);

        // Frame B: test pattern, enable dropped around line 20.
        repeat (6000) tick();
        enable = 0;
        wait_fd(2);
        check("B_read_count", rd_cnt, 0);
        check("B_image_errors", count_bad(1), 0);
        run_probes(1);
        nz = 0;
        repeat (400) begin
            tick();
            if (outs() != 32'd0) nz++;
        end
        check("idle_after_drop_nonzero", nz, 0);
        check("frame_done_once", fd_cnt, 2);
        check("no_frame_after_drop", fr_rise_cnt, 2);

        // Frame C: reset mid-active, then frame D must restart from address 0.
        pattern_sel = 0;
        enable = 1;
        for (int i = 0; i < 3000 && pix < 3*H_PIX + 30; i++) tick();
        check("C_reached_mid_line", 32'(pix >= 3*H_PIX + 30), 32'd1);
        #1 rst_n = 0;
        #1 check("async_reset_outputs", outs(), 32'd0);
        repeat (3) tick();
        check("held_reset_outputs", outs(), 32'd0);
        rst_n = 1;
        tick();
        check("vsetup_after_release", {oclk, ovsync}, 32'd1);
        for (int i = 0; i < 20 && !rd_en; i++) tick();
        check("restart_rd_en", rd_en, 1);
        check("restart_addr", rd_addr, 0);
        wait_fd(3);
        check("D_read_count", rd_cnt, NPIX);
        check("D_addr_order_errors", addr_bad, 0);
        check("D_image_errors", count_bad(0), 0);
        enable = 0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
